nibbler_bus_arbiter: RTL and testbench

Round-robin arbiter for the Nibbler shared 4-bit data bus. It takes up to four bus-request lines from the units that own bus drivers (ALU result, RAM, IN port, immediate/operand path). It produces one-hot output-enable lines that feed those units' bus drivers directly. Every ownership change passes through a programmable dead (turnaround) period, so two drivers never drive the bus in the same cycle. A single owner's tenure is capped when other requesters are waiting.

---
 rtl/nibbler_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_nibbler_bus_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibbler_bus_arbiter.sv
// Round-robin owner arbiter for the Nibbler 4-bit data bus.
// Every change of owner passes through a dead period, and a contended owner's tenure is capped at MAX_HOLD cycles.
module nibbler_bus_arbiter #(
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_req,
  output logic [3:0] o_en,
  output logic [1:0] o_grant_id,
  output logic       o_bus_busy,
  output logic       o_preempt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TURN,
    S_OWN
  } state_t;

  localparam logic [1:0] TURN_INIT = 2'(TURN_CYC);
  localparam logic [3:0] HOLD_MAX  = 4'(MAX_HOLD);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [1:0] r_turn_cnt, w_turn_nxt;
  logic [3:0] r_hold_cnt, w_hold_nxt;
  logic [1:0] r_grant_id, w_grant_nxt;
  logic [3:0] r_en, w_en_nxt;
  logic       r_preempt, w_preempt_nxt;

  logic [2:0] w_pick_idle;
  logic [2:0] w_pick_rel;
  logic [1:0] w_ptr_rel;
  logic       w_others;
  logic       w_owner_req;
  logic       w_expired;

  // Returns {found, index}: first set request scanning upward from ptr, modulo 4.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    w_ptr_rel   = r_grant_id + 2'd1;
    w_pick_idle = pick(i_req, r_ptr);
    w_pick_rel  = pick(i_req, w_ptr_rel);
    w_owner_req = i_req[r_grant_id];
    w_others    = |(i_req & ~(4'b0001 << r_grant_id));
    w_expired   = (r_hold_cnt >= HOLD_MAX) && w_others;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_turn_nxt    = r_turn_cnt;
    w_hold_nxt    = r_hold_cnt;
    w_grant_nxt   = r_grant_id;
    w_preempt_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_idle[2]) begin
          w_state_nxt = S_TURN;
          w_grant_nxt = w_pick_idle[1:0];
          w_turn_nxt  = TURN_INIT;
        end
      end
      S_TURN: begin
        if (r_turn_cnt <= 2'd1) begin
          w_turn_nxt = 2'd0;
          if (w_owner_req) begin
            w_state_nxt = S_OWN;
            w_hold_nxt  = 4'd1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_turn_nxt = r_turn_cnt - 2'd1;
        end
      end
      S_OWN: begin
        // A normal release takes precedence, so preempt only fires while the owner still requests.
        if (!w_owner_req || w_expired) begin
          w_preempt_nxt = w_owner_req;
          w_ptr_nxt     = w_ptr_rel;
          w_hold_nxt    = 4'd0;
          if (w_pick_rel[2]) begin
            w_state_nxt = S_TURN;
            w_grant_nxt = w_pick_rel[1:0];
            w_turn_nxt  = TURN_INIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (r_hold_cnt != 4'd15) begin
          w_hold_nxt = r_hold_cnt + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_en_nxt = 4'b0000;
    if (w_state_nxt == S_OWN) w_en_nxt = 4'b0001 << w_grant_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'd0;
      r_turn_cnt <= 2'd0;
      r_hold_cnt <= 4'd0;
      r_grant_id <= 2'd0;
      r_en       <= 4'b0000;
      r_preempt  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_turn_cnt <= w_turn_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_grant_id <= w_grant_nxt;
      r_en       <= w_en_nxt;
      r_preempt  <= w_preempt_nxt;
    end
  end

  assign o_en       = r_en;
  assign o_grant_id = r_grant_id;
  assign o_bus_busy = (r_state != S_IDLE);
  assign o_preempt  = r_preempt;

endmodule

// File: tb/tb_nibbler_bus_arbiter.sv
// Directed bench for nibbler_bus_arbiter: default, long-turnaround and short-hold instances.
module tb_nibbler_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] reqA = 4'b0, reqB = 4'b0, reqC = 4'b0;
  logic [3:0] enA, enB, enC;
  logic [1:0] grantA, grantB, grantC;
  logic       busyA, busyB, busyC;
  logic       preemptA, preemptB, preemptC;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  nibbler_bus_arbiter dutA (
    .i_clk(clk), .i_reset(reset), .i_req(reqA), .o_en(enA),
    .o_grant_id(grantA), .o_bus_busy(busyA), .o_preempt(preemptA)
  );

  nibbler_bus_arbiter #(.TURN_CYC(3), .MAX_HOLD(4)) dutB (
    .i_clk(clk), .i_reset(reset), .i_req(reqB), .o_en(enB),
    .o_grant_id(grantB), .o_bus_busy(busyB), .o_preempt(preemptB)
  );

  nibbler_bus_arbiter #(.TURN_CYC(1), .MAX_HOLD(2)) dutC (
    .i_clk(clk), .i_reset(reset), .i_req(reqC), .o_en(enC),
    .o_grant_id(grantC), .o_bus_busy(busyC), .o_preempt(preemptC)
  );

  // Advance past one rising edge so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({enA, enB, enC} !== 12'h000) begin
      errors++; $display("[TB] FAIL reset_en: got %h expected 000", {enA, enB, enC});
    end
    checks++;
    if ({busyA, busyB, busyC, preemptA, preemptB, preemptC} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 000000",
                         {busyA, busyB, busyC, preemptA, preemptB, preemptC});
    end
    checks++;
    if ({grantA, grantB, grantC} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_grant: got %b expected 000000", {grantA, grantB, grantC});
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({enA, grantA, busyA} !== 7'b0) begin
        errors++; $display("[TB] FAIL idle_cycle%0d: got en=%b grant=%0d busy=%b expected all zero",
                           i, enA, grantA, busyA);
      end
    end
  endtask

  task automatic test_single();
    reqA = 4'b0001;
    tick();
    checks++;
    if ({busyA, grantA, enA} !== {1'b1, 2'd0, 4'b0000}) begin
      errors++; $display("[TB] FAIL single_e0: got busy=%b grant=%0d en=%b expected 1 0 0000",
                         busyA, grantA, enA);
    end
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if ({enA, preemptA} !== {4'b0001, 1'b0}) begin
        errors++; $display("[TB] FAIL single_own_e%0d: got en=%b preempt=%b expected 0001 0",
                           e, enA, preemptA);
      end
    end
    reqA = 4'b0000;
    tick();
    checks++;
    if ({enA, busyA, preemptA} !== 6'b0) begin
      errors++; $display("[TB] FAIL single_release: got en=%b busy=%b preempt=%b expected 0000 0 0",
                         enA, busyA, preemptA);
    end
    // Pointer is now 1, so requester 3 beats requester 0.
    reqA = 4'b1001;
    tick();
    checks++;
    if ({busyA, grantA} !== {1'b1, 2'd3}) begin
      errors++; $display("[TB] FAIL single_ptr: got busy=%b grant=%0d expected 1 3", busyA, grantA);
    end
    tick();
    checks++;
    if (enA !== 4'b1000) begin
      errors++; $display("[TB] FAIL single_ptr_en: got %b expected 1000", enA);
    end
    reqA = 4'b0000;
    tick();
    checks++;
    if ({enA, busyA} !== 5'b0) begin
      errors++; $display("[TB] FAIL single_idle: got en=%b busy=%b expected 0000 0", enA, busyA);
    end
  endtask

  task automatic test_round_robin();
    int owners[5]  = '{0, 1, 2, 3, 0};
    int nextOwn[5] = '{1, 2, 3, 0, 1};
    logic [3:0] expEn;
    logic [1:0] expGrant;
    reqA = 4'b1111;
    tick();
    checks++;
    if ({busyA, grantA, enA} !== {1'b1, 2'd0, 4'b0000}) begin
      errors++; $display("[TB] FAIL rr_start: got busy=%b grant=%0d en=%b expected 1 0 0000",
                         busyA, grantA, enA);
    end
    for (int i = 0; i < 5; i++) begin
      expEn = 4'b0001 << owners[i];
      expGrant = 2'(nextOwn[i]);
      for (int c = 0; c < 4; c++) begin
        tick();
        checks++;
        if ({enA, preemptA} !== {expEn, 1'b0}) begin
          errors++; $display("[TB] FAIL rr_own%0d_cyc%0d: got en=%b preempt=%b expected %b 0",
                             i, c, enA, preemptA, expEn);
        end
      end
      tick();
      checks++;
      if ({enA, preemptA, busyA, grantA} !== {4'b0000, 1'b1, 1'b1, expGrant}) begin
        errors++; $display("[TB] FAIL rr_preempt%0d: got en=%b preempt=%b busy=%b grant=%0d expected 0000 1 1 %0d",
                           i, enA, preemptA, busyA, grantA, expGrant);
      end
    end
    reqA = 4'b0000;
    tick();
    checks++;
    if ({enA, busyA, preemptA} !== 6'b0) begin
      errors++; $display("[TB] FAIL rr_end: got en=%b busy=%b preempt=%b expected 0000 0 0",
                         enA, busyA, preemptA);
    end
  endtask

  task automatic test_withdraw();
    reqB = 4'b0100;
    tick();
    checks++;
    if ({busyB, grantB, enB} !== {1'b1, 2'd2, 4'b0000}) begin
      errors++; $display("[TB] FAIL wd_latch: got busy=%b grant=%0d en=%b expected 1 2 0000",
                         busyB, grantB, enB);
    end
    tick();
    reqB = 4'b0000;
    tick();
    checks++;
    if ({busyB, enB} !== {1'b1, 4'b0000}) begin
      errors++; $display("[TB] FAIL wd_turn: got busy=%b en=%b expected 1 0000", busyB, enB);
    end
    tick();
    checks++;
    if ({busyB, enB} !== 5'b0) begin
      errors++; $display("[TB] FAIL wd_idle: got busy=%b en=%b expected 0 0000", busyB, enB);
    end
    // Pointer stayed at 0, so requester 0 wins; enable arrives TURN_CYC edges later.
    reqB = 4'b1001;
    tick();
    checks++;
    if ({busyB, grantB} !== {1'b1, 2'd0}) begin
      errors++; $display("[TB] FAIL wd_ptr: got busy=%b grant=%0d expected 1 0", busyB, grantB);
    end
    for (int e = 1; e <= 2; e++) begin
      tick();
      checks++;
      if (enB !== 4'b0000) begin
        errors++; $display("[TB] FAIL wd_dead_e%0d: got %b expected 0000", e, enB);
      end
    end
    tick();
    checks++;
    if (enB !== 4'b0001) begin
      errors++; $display("[TB] FAIL wd_latency: got %b expected 0001", enB);
    end
    reqB = 4'b0000;
    tick();
  endtask

  task automatic test_release_vs_preempt();
    reqC = 4'b0010;
    tick();
    tick();
    checks++;
    if (enC !== 4'b0010) begin
      errors++; $display("[TB] FAIL rp_own: got %b expected 0010", enC);
    end
    reqC = 4'b1010;
    tick();
    checks++;
    if ({enC, preemptC} !== {4'b0010, 1'b0}) begin
      errors++; $display("[TB] FAIL rp_hold2: got en=%b preempt=%b expected 0010 0", enC, preemptC);
    end
    reqC = 4'b1000;
    tick();
    checks++;
    if ({enC, preemptC, busyC, grantC} !== {4'b0000, 1'b0, 1'b1, 2'd3}) begin
      errors++; $display("[TB] FAIL rp_release: got en=%b preempt=%b busy=%b grant=%0d expected 0000 0 1 3",
                         enC, preemptC, busyC, grantC);
    end
    tick();
    checks++;
    if (enC !== 4'b1000) begin
      errors++; $display("[TB] FAIL rp_next: got %b expected 1000", enC);
    end
    reqC = 4'b1001;
    tick();
    checks++;
    if ({enC, preemptC} !== {4'b1000, 1'b0}) begin
      errors++; $display("[TB] FAIL rp_cap_hold: got en=%b preempt=%b expected 1000 0", enC, preemptC);
    end
    tick();
    checks++;
    if ({enC, preemptC, grantC} !== {4'b0000, 1'b1, 2'd0}) begin
      errors++; $display("[TB] FAIL rp_cap_preempt: got en=%b preempt=%b grant=%0d expected 0000 1 0",
                         enC, preemptC, grantC);
    end
    reqC = 4'b0000;
    tick();
    checks++;
    if ({busyC, preemptC} !== 2'b00) begin
      errors++; $display("[TB] FAIL rp_idle: got busy=%b preempt=%b expected 0 0", busyC, preemptC);
    end
  endtask

  task automatic test_reset_mid();
    reqA = 4'b0010;
    tick();
    tick();
    checks++;
    if (enA !== 4'b0010) begin
      errors++; $display("[TB] FAIL rm_own: got %b expected 0010", enA);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({enA, busyA, grantA} !== 7'b0) begin
      errors++; $display("[TB] FAIL rm_reset: got en=%b busy=%b grant=%0d expected 0000 0 0",
                         enA, busyA, grantA);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({busyA, grantA, enA} !== {1'b1, 2'd1, 4'b0000}) begin
      errors++; $display("[TB] FAIL rm_rearb: got busy=%b grant=%0d en=%b expected 1 1 0000",
                         busyA, grantA, enA);
    end
    tick();
    checks++;
    if (enA !== 4'b0010) begin
      errors++; $display("[TB] FAIL rm_regrant: got %b expected 0010", enA);
    end
    reqA = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_withdraw();
    test_release_vs_preempt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
